// File: rtl/dht11_reader.sv
// dht11_reader: single-wire DHT11 master that issues the start pulse, times 40 data bits and checks the checksum
// Ports: clk/rst (sync active-high), start request, dht_in (async pad level),
// dht_oe (1 = pull line low), busy, data_valid / checksum_err / timeout_err one-cycle pulses,
// hum_int/hum_dec/temp_int/temp_dec hold the last frame with a good checksum.
module dht11_reader #(
  parameter int CLK_PER_US    = 50,
  parameter int START_LOW_US  = 18000,
  parameter int TIMEOUT_US    = 200,
  parameter int BIT_THRESH_US = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dht_in,
  output logic       dht_oe,
  output logic       busy,
  output logic       data_valid,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec,
  output logic       checksum_err,
  output logic       timeout_err
);
  localparam int START_CYC = START_LOW_US * CLK_PER_US;
  localparam int TMO_CYC   = TIMEOUT_US * CLK_PER_US;
  localparam int THR_CYC   = BIT_THRESH_US * CLK_PER_US;
  localparam int MAX_CYC   = START_CYC > TMO_CYC ? START_CYC : TMO_CYC;
  localparam int CW        = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic [39:0]   frame_q, frame_d;
  logic [31:0]   out_q, out_d;
  logic          dv_q, dv_d, ce_q, ce_d;
  logic          s1_q, s2_q, s3_q;
  logic          rise, fall, wait_st, tmo;
  logic [7:0]    sum;

  assign rise    = s2_q & ~s3_q;
  assign fall    = ~s2_q & s3_q;
  assign wait_st = state_q inside {RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH};
  assign tmo     = wait_st && cnt_q == CW'(TMO_CYC);

  assign dht_oe       = state_q == START_LOW;
  assign busy         = state_q != IDLE;
  assign data_valid   = dv_q;
  assign checksum_err = ce_q;
  assign timeout_err  = tmo;
  assign {hum_int, hum_dec, temp_int, temp_dec} = out_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    out_d     = out_q;
    dv_d      = 1'b0;
    ce_d      = 1'b0;
    sum       = '0;
    if (tmo) state_d = IDLE;
    else
      case (state_q)
        IDLE:      state_d = start ? START_LOW : IDLE;
        START_LOW: state_d = cnt_q == CW'(START_CYC - 1) ? RELEASE : START_LOW;
        RELEASE:   state_d = fall ? RESP_LOW : RELEASE;
        RESP_LOW:  state_d = rise ? RESP_HIGH : RESP_LOW;
        RESP_HIGH: begin
          state_d   = fall ? BIT_LOW : RESP_HIGH;
          bit_cnt_d = '0;
        end
        BIT_LOW:   state_d = rise ? BIT_HIGH : BIT_LOW;
        BIT_HIGH: if (fall) begin
          // cnt_q + 1 is the high time in cycles, so cnt_q >= THR means high time > THR
          frame_d   = {frame_q[38:0], cnt_q >= CW'(THR_CYC)};
          bit_cnt_d = bit_cnt_q + 6'd1;
          state_d   = bit_cnt_q == 6'd39 ? CHECK : BIT_LOW;
          // result is registered on entry to CHECK so pulses and data appear together
          if (bit_cnt_q == 6'd39) begin
            sum   = frame_d[39:32] + frame_d[31:24] + frame_d[23:16] + frame_d[15:8];
            dv_d  = sum == frame_d[7:0];
            ce_d  = sum != frame_d[7:0];
            out_d = sum == frame_d[7:0] ? frame_d[39:8] : out_q;
          end
        end
        default:   state_d = IDLE;
      endcase
    cnt_d = state_d != state_q ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      frame_q   <= '0;
      out_q     <= '0;
      dv_q      <= 1'b0;
      ce_q      <= 1'b0;
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      s3_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      out_q     <= out_d;
      dv_q      <= dv_d;
      ce_q      <= ce_d;
      s1_q      <= dht_in;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
    end
  end
endmodule

// File: doc/dht11_reader.md
# dht11_reader

Single-wire DHT11 protocol master. On a `start` request it drives the host start pulse, checks the sensor's response preamble, and times 40 data bits. It verifies the checksum and presents humidity and temperature bytes with a one-cycle valid strobe. It sits between the bidirectional sensor pad (external open-drain buffer) and the downstream display/processing logic that consumes the readings.

## Interface
- `CLK_PER_US`, 50: clock cycles per microsecond; all timing is derived from it.
- `START_LOW_US`, 18000: host start pulse length in µs.
- `TIMEOUT_US`, 200: maximum time in any sensor-wait state before abort.
- `BIT_THRESH_US`, 50: high-phase length threshold for a data bit.
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a reading; sampled only in IDLE.
- `dht_in` input 1: sensor line level, asynchronous to `clk`.
- `dht_oe` output 1: 1 = pull line low; 0 = release the line (pull-up).
- `busy` output 1: high in every state except IDLE.
- `data_valid` output 1: one-cycle pulse; new readings are valid.
- `hum_int`, `hum_dec`, `temp_int`, `temp_dec` output 8 each: last good frame, bytes 0–3.
- `checksum_err` output 1: one-cycle pulse on checksum mismatch.
- `timeout_err` output 1: one-cycle pulse on a wait-state timeout.

## Operation
- `dht_in` passes through a 2-flop synchronizer. Edges are detected on the synchronized signal against a third registered copy.
- A single cycle counter clears on every state entry. All limits are expressed as `X_US*CLK_PER_US` cycles.
- FSM states and transitions:
  - **IDLE**: `dht_oe=0`. `start=1` moves to START_LOW.
  - **START_LOW**: `dht_oe=1` for exactly `START_LOW_US*CLK_PER_US` cycles, then go to RELEASE.
  - **RELEASE**: `dht_oe=0`. Wait for a falling edge, then go to RESP_LOW.
  - **RESP_LOW**: wait for a rising edge, then go to RESP_HIGH.
  - **RESP_HIGH**: wait for a falling edge, then go to BIT_LOW. The bit count is cleared.
  - **BIT_LOW**: wait for a rising edge, then go to BIT_HIGH.
  - **BIT_HIGH**: on a falling edge, shift in bit = (counter > `BIT_THRESH_US*CLK_PER_US`). Shifting is MSB first into a 40-bit register. Increment the bit count. If the count reaches 40, go to CHECK; otherwise go to BIT_LOW.
  - **CHECK**: one cycle.
    - If (byte0+byte1+byte2+byte3) mod 256 == byte4: load the four output registers and pulse `data_valid`.
    - Otherwise pulse `checksum_err`; the output registers hold their previous values.
    - Then go to IDLE.
- Timeout: in RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW or BIT_HIGH, the counter reaching `TIMEOUT_US*CLK_PER_US` pulses `timeout_err` and returns to IDLE. Output registers are unchanged.
- `start` while `busy` is ignored and not queued.
- The block does not wait for the sensor's trailing release after bit 40.

## Timing
- Reset values: `dht_oe=0`, `busy=0`, `data_valid=0`, both error flags 0, all data outputs 0x00, state IDLE.
- `rst` mid-operation: the next cycle is in reset state with the line released; any partial frame is discarded.
- `dht_oe` rises 1 cycle after `start` is sampled in IDLE.
- `dht_oe` stays high exactly `START_LOW_US*CLK_PER_US` cycles.
- `dht_in` edges are seen 3 cycles after the pad transition. Bit high-time is measured between synchronized edges, so the latency cancels.
- Bit threshold: a counter equal to the threshold decodes 0; threshold+1 decodes 1.
- `data_valid` / `checksum_err` are asserted in the cycle after the 40th falling edge is detected. Data outputs update in that same cycle.
- `busy` drops the cycle after CHECK or after a timeout pulse.
- `data_valid`, `checksum_err` and `timeout_err` are mutually exclusive and never high for more than one cycle.

## Test plan
Bench parameters: `CLK_PER_US=1`, `START_LOW_US=20`, `TIMEOUT_US=200`, `BIT_THRESH_US=50`. The sensor model uses an 80/80 preamble, 50-cycle bit lows, 26-cycle high for 0 and 70-cycle high for 1.
- Frame 0x37,0x00,0x19,0x00,0x50 -> one `data_valid` pulse; `hum_int=55`, `temp_int=25`, decimals 0; no error pulses.
- Then frame 0x37,0x00,0x19,0x00,0x51 -> one `checksum_err` pulse, no `data_valid`; outputs still 55/25.
- `start` with the sensor silent (`dht_in` held 1) -> `dht_oe` high exactly 20 cycles; `timeout_err` pulse 200 cycles after release; `busy=0` next cycle.
- Second `start` pulse while busy -> ignored; exactly one start pulse and one frame are observed.
- `rst` after 10 bits received -> `dht_oe=0`, `busy=0`, outputs 0x00; the next full frame 0x40,0x00,0x1E,0x00,0x5E decodes to 64/30.
- Bit highs of 50 and 51 cycles in byte0 bits 7 and 6 (rest 0s, checksum adjusted) -> `hum_int=0x40`.
